// File: rtl/uart_rx_fifo_if.sv
// CPU-side read and status bus of the UART receiver.
// The receiver uses the slave modport. The register/CPU side uses the master modport.
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Handshake: rd_valid high means rd_data/rd_err show the FIFO head. Any cycle with
   // rd_en && rd_valid pops that head. rd_en while empty is ignored. lsr_rd is a
   // one-cycle strobe that clears the sticky status bits.
   logic          rd_en;
   logic [7:0]    rd_data;
   logic [2:0]    rd_err;
   logic          rd_valid;
   logic [CW-1:0] fifo_count;
   logic          lsr_rd;
   logic [7:0]    lsr;
   logic          irq;

   modport master (
      output rd_en, lsr_rd,
      input  rd_data, rd_err, rd_valid, fifo_count, lsr, irq
   );

   modport slave (
      input  rd_en, lsr_rd,
      output rd_data, rd_err, rd_valid, fifo_count, lsr, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote sampling, show-ahead RX FIFO,
// break detection, overrun detection, 16550-style sticky line status and a level interrupt.
module uart_rx_fifo #(
   parameter int OSR         = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bclk,
   input  logic                   rx,
   input  logic [7:0]             lcr,
   input  logic [7:0]             ier,
   uart_rx_fifo_if.slave          bus,
   output logic [2:0]             dbg_state,
   output logic [$clog2(OSR)-1:0] dbg_tick
);
   localparam int TW = $clog2(OSR);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [TW-1:0] T_S0  = TW'(OSR / 2 - 1);
   localparam logic [TW-1:0] T_S1  = TW'(OSR / 2);
   localparam logic [TW-1:0] T_S2  = TW'(OSR / 2 + 1);
   localparam logic [TW-1:0] T_END = TW'(OSR - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      BREAK_WAIT = 3'd5
   } state_t;

   // ---------------------------------------------------------------- synchroniser
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- receive FSM
   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    samp_q, samp_d;
   logic [5:0]    lcr_q, lcr_d;
   logic          par_err_q, par_err_d;
   logic          any_one_q, any_one_d;

   logic          maj;
   logic          decide;
   logic          wrap;
   logic [2:0]    last_bit;
   logic          par_exp;
   logic          push;
   logic [7:0]    push_data;
   logic [2:0]    push_err;

   assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
   assign decide   = (tick_q == T_S2);
   assign wrap     = (tick_q == T_END);
   assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
   // Upper data bits are cleared at frame start, so the full-byte XOR is the XOR of the received bits.
   assign par_exp  = lcr_q[5] ? ~lcr_q[4] : (lcr_q[4] ? ^shift_q : ~(^shift_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         samp_q    <= '0;
         lcr_q     <= '0;
         par_err_q <= 1'b0;
         any_one_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         samp_q    <= samp_d;
         lcr_q     <= lcr_d;
         par_err_q <= par_err_d;
         any_one_q <= any_one_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      samp_d    = samp_q;
      lcr_d     = lcr_q;
      par_err_d = par_err_q;
      any_one_d = any_one_q;
      push      = 1'b0;
      push_data = shift_q;
      push_err  = {1'b0, ~maj, par_err_q};

      if (bclk) begin
         tick_d = wrap ? '0 : tick_q + 1'b1;
         if (tick_q == T_S0) samp_d[0] = rx_s;
         if (tick_q == T_S1) samp_d[1] = rx_s;

         case (state_q)
            IDLE: begin
               tick_d = '0;
               if (!rx_s) begin
                  state_d   = START;
                  lcr_d     = lcr[5:0];
                  shift_d   = '0;
                  bit_d     = '0;
                  par_err_d = 1'b0;
                  any_one_d = 1'b0;
               end
            end

            START: begin
               if (decide && maj) state_d = IDLE;
               else if (wrap)     state_d = DATA;
            end

            DATA: begin
               if (decide) begin
                  shift_d[bit_q] = maj;
                  any_one_d      = any_one_q | maj;
               end
               if (wrap) begin
                  if (bit_q == last_bit) state_d = lcr_q[3] ? PARITY : STOP;
                  else                   bit_d   = bit_q + 3'd1;
               end
            end

            PARITY: begin
               if (decide) begin
                  par_err_d = (maj != par_exp);
                  any_one_d = any_one_q | maj;
               end
               if (wrap) state_d = STOP;
            end

            // Only the first stop bit is checked. The character is pushed at its decision point.
            STOP: begin
               if (decide) begin
                  push = 1'b1;
                  if (!maj && !any_one_q) begin
                     push_data = '0;
                     push_err  = 3'b110;
                     state_d   = BREAK_WAIT;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end

            BREAK_WAIT: begin
               tick_d = '0;
               if (rx_s) state_d = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   assign dbg_state = state_q;
   assign dbg_tick  = tick_q;

   // ---------------------------------------------------------------- RX FIFO
   logic [10:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] flag_cnt_q;
   logic [10:0]   head;
   logic          empty, full;
   logic          pop, wr, ovr;
   logic          head_flagged;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(FIFO_DEPTH));
   assign pop          = bus.rd_en && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
   assign wr           = push && (!full || pop);
   assign ovr          = push && full && !pop;
   assign head         = mem_q[rd_ptr_q];
   assign head_flagged = |head[10:8];

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= {push_err, push_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flag_cnt_q <= '0;
      end else begin
         if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_q + CW'(wr) - CW'(pop);
         flag_cnt_q <= flag_cnt_q + CW'(wr && (|push_err)) - CW'(pop && head_flagged);
      end
   end

   // ---------------------------------------------------------------- line status
   logic oe_q, pe_q, fe_q, bi_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         oe_q <= 1'b0;
         pe_q <= 1'b0;
         fe_q <= 1'b0;
         bi_q <= 1'b0;
      end else begin
         oe_q <= ovr                | (oe_q & ~bus.lsr_rd);
         pe_q <= (wr & push_err[0]) | (pe_q & ~bus.lsr_rd);
         fe_q <= (wr & push_err[1]) | (fe_q & ~bus.lsr_rd);
         bi_q <= (wr & push_err[2]) | (bi_q & ~bus.lsr_rd);
      end
   end

   assign bus.rd_valid   = !empty;
   assign bus.rd_data    = empty ? 8'h00 : head[7:0];
   assign bus.rd_err     = empty ? 3'b000 : head[10:8];
   assign bus.fifo_count = count_q;
   assign bus.lsr        = {(flag_cnt_q != '0), 2'b00, bi_q, fe_q, pe_q, oe_q, !empty};
   assign bus.irq        = (ier[0] & !empty) | (ier[2] & (oe_q | pe_q | fe_q | bi_q));

   logic unused_inputs;
   assign unused_inputs = ^{lcr[7:6], ier[7:3], ier[1]};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven at OSR bclk ticks per bit,
// with the FIFO and line status checked against hand-computed values.
module tb_uart_rx_fifo;
   localparam int OSR        = 16;
   localparam int FIFO_DEPTH = 8;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BREAK = 3'd5;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       bclk  = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] lcr   = 8'h03;
   logic [7:0] ier   = 8'h00;
   logic [2:0] dbg_state;
   logic [3:0] dbg_tick;
   int         bcnt  = 0;
   int         checks = 0;
   int         errors = 0;

   uart_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   uart_rx_fifo #(.OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .bclk      (bclk),
      .rx        (rx),
      .lcr       (lcr),
      .ier       (ier),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_tick  (dbg_tick)
   );

   // ---------------------------------------------------------------- clock/reset and bclk
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bcnt == 3) begin
         bcnt <= 0;
         bclk <= 1'b1;
      end else begin
         bcnt <= bcnt + 1;
         bclk <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_bclk(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk);
         if (bclk) k++;
      end
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_bclk(OSR);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                             input logic pbit, input logic sbit);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (pen) send_bit(pbit);
      send_bit(sbit);
      rx = 1'b1;
      wait_bclk(2 * OSR);
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic read_lsr();
      bus.lsr_rd = 1'b1;
      @(posedge clk);
      #1;
      bus.lsr_rd = 1'b0;
   endtask

   // ---------------------------------------------------------------- directed sequence
   initial begin
      logic found;
      bus.rd_en  = 1'b0;
      bus.lsr_rd = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_valid", 32'(bus.rd_valid), 32'h0);
      check("reset_count", 32'(bus.fifo_count), 32'h0);
      check("reset_lsr", 32'(bus.lsr), 32'h00);
      check("reset_data", 32'(bus.rd_data), 32'h00);
      check("reset_irq", 32'(bus.irq), 32'h0);
      check("reset_state", 32'(dbg_state), 32'(S_IDLE));
      reset = 1'b0;
      wait_bclk(OSR);

      // 8N1 0xA5
      lcr = 8'h03;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      check("a5_valid", 32'(bus.rd_valid), 32'h1);
      check("a5_data", 32'(bus.rd_data), 32'hA5);
      check("a5_err", 32'(bus.rd_err), 32'h0);
      check("a5_lsr", 32'(bus.lsr), 32'h01);
      check("a5_count", 32'(bus.fifo_count), 32'h1);
      ier = 8'h01;
      #1;
      check("a5_irq_dr", 32'(bus.irq), 32'h1);
      pop();
      check("a5_pop_valid", 32'(bus.rd_valid), 32'h0);
      check("a5_pop_lsr", 32'(bus.lsr), 32'h00);
      check("a5_pop_irq", 32'(bus.irq), 32'h0);

      // 7E1 0x35 with a wrong parity bit
      ier = 8'h04;
      lcr = 8'h1A;
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
      lcr = 8'h03;
      check("pe_data", 32'(bus.rd_data), 32'h35);
      check("pe_err", 32'(bus.rd_err), 32'h1);
      check("pe_lsr", 32'(bus.lsr), 32'h85);
      check("pe_irq", 32'(bus.irq), 32'h1);
      read_lsr();
      check("pe_lsr_clr", 32'(bus.lsr), 32'h81);
      check("pe_irq_clr", 32'(bus.irq), 32'h0);
      pop();
      check("pe_pop_lsr", 32'(bus.lsr), 32'h00);
      check("pe_pop_irq", 32'(bus.irq), 32'h0);

      // 8N1 0x3C with stop bit 0
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      check("fe_data", 32'(bus.rd_data), 32'h3C);
      check("fe_err", 32'(bus.rd_err), 32'h2);
      check("fe_lsr", 32'(bus.lsr), 32'h89);
      check("fe_count", 32'(bus.fifo_count), 32'h1);
      check("fe_state", 32'(dbg_state), 32'(S_IDLE));
      pop();
      read_lsr();

      // break: rx low for 30 bit times
      rx = 1'b0;
      wait_bclk(30 * OSR);
      check("brk_count_low", 32'(bus.fifo_count), 32'h1);
      check("brk_state", 32'(dbg_state), 32'(S_BREAK));
      check("brk_data", 32'(bus.rd_data), 32'h00);
      check("brk_err", 32'(bus.rd_err), 32'h6);
      check("brk_lsr", 32'(bus.lsr), 32'h99);
      rx = 1'b1;
      wait_bclk(2 * OSR);
      check("brk_count_high", 32'(bus.fifo_count), 32'h1);
      check("brk_state_idle", 32'(dbg_state), 32'(S_IDLE));
      pop();
      read_lsr();
      check("brk_lsr_clr", 32'(bus.lsr), 32'h00);

      // 5-tick glitch, then a valid 0x55
      rx = 1'b0;
      wait_bclk(5);
      rx = 1'b1;
      wait_bclk(2 * OSR);
      check("glitch_count", 32'(bus.fifo_count), 32'h0);
      check("glitch_state", 32'(dbg_state), 32'(S_IDLE));
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
      check("glitch_next_data", 32'(bus.rd_data), 32'h55);
      check("glitch_next_err", 32'(bus.rd_err), 32'h0);
      pop();

      // overrun: 9 frames without reads
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
      check("ovr_count", 32'(bus.fifo_count), 32'h8);
      check("ovr_oe", 32'(bus.lsr[1]), 32'h1);
      check("ovr_head", 32'(bus.rd_data), 32'h01);
      for (int i = 1; i <= 8; i++) begin
         check("ovr_drain", 32'(bus.rd_data), 32'(i));
         pop();
      end
      check("ovr_empty", 32'(bus.fifo_count), 32'h0);
      read_lsr();
      check("ovr_lsr_clr", 32'(bus.lsr), 32'h00);

      // full FIFO, ninth frame pushed while rd_en pops the head
      for (int i = 1; i <= 8; i++) send_frame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
      check("full_count", 32'(bus.fifo_count), 32'h8);
      found = 1'b0;
      fork
         send_frame(8'h19, 8, 1'b0, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 2000 && !found; i++) begin
               @(posedge clk);
               #1;
               if (dbg_state == S_STOP && dbg_tick == 4'(OSR / 2 + 1) && bclk) begin
                  found = 1'b1;
                  bus.rd_en = 1'b1;
                  @(posedge clk);
                  #1;
                  bus.rd_en = 1'b0;
               end
            end
         end
      join
      check("full_push_seen", 32'(found), 32'h1);
      check("full_pp_count", 32'(bus.fifo_count), 32'h8);
      check("full_pp_oe", 32'(bus.lsr[1]), 32'h0);
      check("full_pp_head", 32'(bus.rd_data), 32'h12);
      for (int i = 2; i <= 9; i++) begin
         check("full_drain", 32'(bus.rd_data), 32'h10 + 32'(i));
         pop();
      end

      // 5-bit stick parity (expected parity 0), 0x1F
      lcr = 8'h38;
      send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
      check("stick_data", 32'(bus.rd_data), 32'h1F);
      check("stick_err", 32'(bus.rd_err), 32'h0);
      check("stick_lsr", 32'(bus.lsr), 32'h01);

      // reset in the middle of DATA
      lcr = 8'h03;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      check("mid_state", 32'(dbg_state), 32'(S_DATA));
      reset = 1'b1;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_count", 32'(bus.fifo_count), 32'h0);
      check("mid_lsr", 32'(bus.lsr), 32'h00);
      check("mid_valid", 32'(bus.rd_valid), 32'h0);
      wait_bclk(3 * OSR);
      check("mid_idle_count", 32'(bus.fifo_count), 32'h0);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
      check("post_data", 32'(bus.rd_data), 32'hC3);
      check("post_err", 32'(bus.rd_err), 32'h0);
      check("post_count", 32'(bus.fifo_count), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
